// File: rtl/pipelined_cs_adder_pkg.sv
// Shared definitions for the pipelined carry-select adder.
//   DefWidth / DefBlock : default operand width and carry-select block width
//   MaxWidth            : widest operand the result struct can carry
//   ErrCountWidth       : width of the optional self-check error counter
//   result_t            : registered result beat (sum, c_out, ovf)
//   sat_inc             : saturating increment for the error counter
package adder_pkg;

  localparam int unsigned DefWidth      = 16;
  localparam int unsigned DefBlock      = 4;
  localparam int unsigned MaxWidth      = 64;
  localparam int unsigned ErrCountWidth = 8;

  // sum is sized for MaxWidth; instances use the low WIDTH bits, the rest stay zero.
  typedef struct packed {
    logic [MaxWidth-1:0] sum;
    logic                c_out;
    logic                ovf;
  } result_t;

  function automatic logic [ErrCountWidth-1:0] sat_inc(input logic [ErrCountWidth-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pipelined_cs_adder_if.sv
// Operand/result handshake bundle for pipelined_cs_adder.
//   master : upstream producer + downstream consumer side (drives operands, out_ready)
//   slave  : the adder (drives in_ready, out_valid, sum, c_out, ovf)
interface pipelined_cs_adder_if #(
  parameter int unsigned WIDTH = adder_pkg::DefWidth
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;

  modport master (
    output in_valid, a, b, c_in, sub, out_ready,
    input  in_ready, out_valid, sum, c_out, ovf
  );

  modport slave (
    input  in_valid, a, b, c_in, sub, out_ready,
    output in_ready, out_valid, sum, c_out, ovf
  );
endinterface

// File: rtl/pipelined_cs_adder_cs_block.sv
// One carry-select slice: two BLOCK-bit ripple adders (carry-in 0 and 1) and a
// select mux driven by the incoming carry.
//   a, b  : slice operands
//   c_in  : carry from the slice below (selects the precomputed result)
//   sum   : slice sum
//   c_out : carry to the slice above
module cs_block #(
  parameter int unsigned BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             c_in,
  output logic [BLOCK-1:0] sum,
  output logic             c_out
);

  logic [BLOCK-1:0] sum0, sum1;
  logic             cout0, cout1;

  always_comb begin
    logic c0, c1;
    c0   = 1'b0;
    c1   = 1'b1;
    sum0 = '0;
    sum1 = '0;
    for (int i = 0; i < int'(BLOCK); i++) begin
      sum0[i] = a[i] ^ b[i] ^ c0;
      c0      = (a[i] & b[i]) | (c0 & (a[i] ^ b[i]));
      sum1[i] = a[i] ^ b[i] ^ c1;
      c1      = (a[i] & b[i]) | (c1 & (a[i] ^ b[i]));
    end
    cout0 = c0;
    cout1 = c1;
  end

  assign sum   = c_in ? sum1 : sum0;
  assign c_out = c_in ? cout1 : cout0;

endmodule

// File: rtl/pipelined_cs_adder.sv
// Two-stage valid/ready pipelined carry-select adder.
//   S1 captures operands; the carry-select adder sits between S1 and S2; S2 holds
//   the result until the consumer takes it.
// Ports:
//   clk   : clock, all state updates on posedge
//   rst_n : synchronous active-low reset
//   bus   : pipelined_cs_adder_if.slave (in_valid/in_ready/a/b/c_in/sub,
//           out_valid/out_ready/sum/c_out/ovf)
// Optional feature (macro ADDER_SELF_CHECK_EN):
//   err       : sticky flag, set when a delivered result disagrees with a plain add
//   err_count : saturating count of such mismatches
module pipelined_cs_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned BLOCK = DefBlock
) (
  input  logic                     clk,
  input  logic                     rst_n,
  pipelined_cs_adder_if.slave      bus
`ifdef ADDER_SELF_CHECK_EN
  ,
  output logic                     err,
  output logic [ErrCountWidth-1:0] err_count
`endif
);

  localparam int unsigned NumBlocks = WIDTH / BLOCK;

  // Stage 1: raw operands
  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_a_q, s1_b_q;
  logic             s1_c_in_q, s1_sub_q;

  // Stage 2: result
  logic             s2_valid_q;
  result_t          s2_res_q, s2_res_d;

  logic s2_adv, in_ready_int;

  // S2 can take a new beat when empty or draining; S1 can then always advance.
  assign s2_adv       = !s2_valid_q || bus.out_ready;
  assign in_ready_int = !s1_valid_q || s2_adv;
  assign bus.in_ready = rst_n && in_ready_int;

  // Subtract: invert b and force carry-in to 1.
  logic [WIDTH-1:0] op_b, add_sum;
  logic             op_c, add_cout;

  assign op_b = s1_sub_q ? ~s1_b_q : s1_b_q;
  assign op_c = s1_sub_q | s1_c_in_q;

  for (genvar g = 0; g < int'(NumBlocks); g++) begin : gen_blk
    logic blk_cin, blk_cout;
    if (g == 0) begin : gen_first
      assign blk_cin = op_c;
    end else begin : gen_rest
      assign blk_cin = gen_blk[g-1].blk_cout;
    end
    cs_block #(
      .BLOCK (BLOCK)
    ) u_cs_block (
      .a     (s1_a_q[g*BLOCK +: BLOCK]),
      .b     (op_b[g*BLOCK +: BLOCK]),
      .c_in  (blk_cin),
      .sum   (add_sum[g*BLOCK +: BLOCK]),
      .c_out (blk_cout)
    );
  end

  assign add_cout = gen_blk[NumBlocks-1].blk_cout;

  always_comb begin
    s2_res_d                = '0;
    s2_res_d.sum[WIDTH-1:0] = add_sum;
    s2_res_d.c_out          = add_cout;
    // Carry into the MSB is recovered from the MSB sum bit.
    s2_res_d.ovf = add_cout ^ (s1_a_q[WIDTH-1] ^ op_b[WIDTH-1] ^ add_sum[WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_c_in_q  <= 1'b0;
      s1_sub_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_res_q   <= '0;
    end else begin
      if (in_ready_int) begin
        s1_valid_q <= bus.in_valid;
        if (bus.in_valid) begin
          s1_a_q    <= bus.a;
          s1_b_q    <= bus.b;
          s1_c_in_q <= bus.c_in;
          s1_sub_q  <= bus.sub;
        end
      end
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_res_q <= s2_res_d;
        end
      end
    end
  end

  assign bus.out_valid = s2_valid_q;
  assign bus.sum       = s2_res_q.sum[WIDTH-1:0];
  assign bus.c_out     = s2_res_q.c_out;
  assign bus.ovf       = s2_res_q.ovf;

  if (WIDTH < MaxWidth) begin : gen_unused_hi
    logic unused_sum_hi;
    assign unused_sum_hi = ^s2_res_q.sum[MaxWidth-1:WIDTH];
  end

`ifdef ADDER_SELF_CHECK_EN
  // Operands travel alongside the result so the delivered beat can be re-added.
  logic [WIDTH-1:0]         s2_a_q, s2_b_q;
  logic                     s2_c_in_q, s2_sub_q;
  logic [WIDTH:0]           chk_full;
  logic [WIDTH-1:0]         chk_b;
  logic                     chk_ovf, chk_mismatch;
  logic                     err_q;
  logic [ErrCountWidth-1:0] err_count_q;

  always_comb begin
    chk_b    = s2_sub_q ? ~s2_b_q : s2_b_q;
    chk_full = {1'b0, s2_a_q} + {1'b0, chk_b} + {{WIDTH{1'b0}}, s2_sub_q | s2_c_in_q};
    chk_ovf  = (s2_a_q[WIDTH-1] == chk_b[WIDTH-1]) && (chk_full[WIDTH-1] != s2_a_q[WIDTH-1]);
    chk_mismatch = (chk_full != {s2_res_q.c_out, s2_res_q.sum[WIDTH-1:0]}) ||
                   (chk_ovf != s2_res_q.ovf);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_a_q      <= '0;
      s2_b_q      <= '0;
      s2_c_in_q   <= 1'b0;
      s2_sub_q    <= 1'b0;
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else begin
      if (s2_adv && s1_valid_q) begin
        s2_a_q    <= s1_a_q;
        s2_b_q    <= s1_b_q;
        s2_c_in_q <= s1_c_in_q;
        s2_sub_q  <= s1_sub_q;
      end
      if (s2_valid_q && bus.out_ready && chk_mismatch) begin
        err_q       <= 1'b1;
        err_count_q <= sat_inc(err_count_q);
      end
    end
  end

  assign err       = err_q;
  assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_pipelined_cs_adder.sv
// Self-checking bench for pipelined_cs_adder (WIDTH=16, BLOCK=4).
// Inputs are driven on the falling edge and outputs inspected 1 ns later.
module tb_pipelined_cs_adder;
  import adder_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pipelined_cs_adder_if #(.WIDTH(16)) bus ();

`ifdef ADDER_SELF_CHECK_EN
  logic                     err;
  logic [ErrCountWidth-1:0] err_count;
`endif

  pipelined_cs_adder #(
    .WIDTH (16),
    .BLOCK (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus)
`ifdef ADDER_SELF_CHECK_EN
    ,
    .err       (err),
    .err_count (err_count)
`endif
  );

  // Reference: integer arithmetic on unsigned and signed views of the operands.
  // Returns {c_out, ovf, sum}.
  function automatic logic [17:0] model(input int unsigned a, input int unsigned b,
                                        input bit cin, input bit sub);
    int          sa, sb, sres;
    int unsigned full;
    logic        c, ov;
    logic [15:0] s;
    sa = (a >= 32768) ? int'(a) - 65536 : int'(a);
    sb = (b >= 32768) ? int'(b) - 65536 : int'(b);
    if (!sub) begin
      full = a + b + 32'(cin);
      c    = (full >= 32'd65536);
      s    = 16'(full);
      sres = sa + sb + int'(cin);
    end else begin
      c    = (a >= b);
      s    = 16'(a - b);
      sres = sa - sb;
    end
    ov = (sres > 32767) || (sres < -32768);
    return {c, ov, s};
  endfunction

  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic sub, input logic ordy);
    bus.in_valid  = v;
    bus.a         = a;
    bus.b         = b;
    bus.c_in      = cin;
    bus.sub       = sub;
    bus.out_ready = ordy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid);
    end
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++; $display("FAIL reset_in_ready got=%b want=0", bus.in_ready);
    end
    checks++;
    if ({bus.c_out, bus.ovf, bus.sum} !== 18'h0) begin
      failures++;
      $display("FAIL reset_result got=%h want=0", {bus.c_out, bus.ovf, bus.sum});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL release_in_ready got=%b want=1", bus.in_ready);
    end
  endtask

  task automatic test_directed();
    logic [15:0] va [3] = '{16'hFFFF, 16'h7FFF, 16'h0003};
    logic [15:0] vb [3] = '{16'h0001, 16'h0001, 16'h0005};
    logic        vs [3] = '{1'b0, 1'b0, 1'b1};
    logic [17:0] ve [3] = '{{1'b1, 1'b0, 16'h0000}, {1'b0, 1'b1, 16'h8000},
                            {1'b0, 1'b0, 16'hFFFE}};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(1'b1, va[k], vb[k], 1'b0, vs[k], 1'b1);
      @(negedge clk);
      drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
      #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin
        failures++; $display("FAIL latency_early vec=%0d got=%b want=0", k, bus.out_valid);
      end
      @(negedge clk);
      #1;
      checks++;
      if (bus.out_valid !== 1'b1 || {bus.c_out, bus.ovf, bus.sum} !== ve[k]) begin
        failures++;
        $display("FAIL directed vec=%0d got v=%b r=%h want v=1 r=%h", k, bus.out_valid,
                 {bus.c_out, bus.ovf, bus.sum}, ve[k]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int stalls = 0, outs = 0, first = -1, last = -1;
    for (int cyc = 0; cyc < 16; cyc++) begin
      @(negedge clk);
      if (cyc < 10) drive(1'b1, 16'(cyc), 16'(cyc), 1'b0, 1'b0, 1'b1);
      else drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
      #1;
      if (cyc < 10 && !bus.in_ready) stalls++;
      if (bus.out_valid) begin
        checks++;
        if (bus.sum !== 16'(2 * outs)) begin
          failures++; $display("FAIL b2b_sum beat=%0d got=%h want=%h", outs, bus.sum,
                               16'(2 * outs));
        end
        if (first < 0) first = cyc;
        last = cyc;
        outs++;
      end
    end
    checks++;
    if (stalls != 0) begin
      failures++; $display("FAIL b2b_in_ready stalls got=%0d want=0", stalls);
    end
    checks++;
    if (outs != 10 || first != 2 || last != 11) begin
      failures++;
      $display("FAIL b2b_stream got outs=%0d first=%0d last=%0d want 10/2/11", outs, first,
               last);
    end
  endtask

  task automatic test_backpressure();
    int          accepted = 0, unstable = 0, outs = 0;
    logic [15:0] got [2];
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      drive(1'b1, 16'(16'h100 + cyc), 16'h0011, 1'b0, 1'b0, 1'b0);
      #1;
      if (bus.in_ready) accepted++;
      if (cyc >= 2 && bus.sum !== 16'h0111) unstable++;
    end
    checks++;
    if (accepted != 2) begin
      failures++; $display("FAIL bp_accepted got=%0d want=2", accepted);
    end
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
      failures++; $display("FAIL bp_stall got in_ready=%b out_valid=%b want 0/1",
                           bus.in_ready, bus.out_valid);
    end
    checks++;
    if (unstable != 0) begin
      failures++; $display("FAIL bp_hold unstable_cycles got=%0d want=0", unstable);
    end
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
      #1;
      if (bus.out_valid) begin
        if (outs < 2) got[outs] = bus.sum;
        outs++;
      end
    end
    checks++;
    if (outs != 2 || got[0] !== 16'h0111 || got[1] !== 16'h0112) begin
      failures++; $display("FAIL bp_release got n=%0d %h %h want 2 0111 0112", outs, got[0],
                           got[1]);
    end
  endtask

  task automatic test_random();
    logic [17:0] exp_q[$];
    logic [17:0] exp, prev;
    logic        prev_stall = 1'b0;
    int          n_out = 0;
    for (int cyc = 0; cyc < 420; cyc++) begin
      logic        v, r, cin, sub;
      logic [15:0] a, b;
      v   = (cyc < 400) && ($urandom_range(9) < 7);
      r   = (cyc >= 400) || ($urandom_range(9) < 7);
      a   = 16'($urandom);
      b   = 16'($urandom);
      if ($urandom_range(7) == 0) a = 16'hFFFF;
      if ($urandom_range(7) == 0) b = 16'h8000;
      cin = 1'($urandom);
      sub = ($urandom_range(3) == 0);
      @(negedge clk);
      drive(v, a, b, cin, sub, r);
      #1;
      if (prev_stall) begin
        checks++;
        if (bus.out_valid !== 1'b1 || {bus.c_out, bus.ovf, bus.sum} !== prev) begin
          failures++; $display("FAIL rand_hold cyc=%0d got v=%b r=%h want v=1 r=%h", cyc,
                               bus.out_valid, {bus.c_out, bus.ovf, bus.sum}, prev);
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev       = {bus.c_out, bus.ovf, bus.sum};
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL rand_extra cyc=%0d got=%h want=none", cyc, prev);
        end else begin
          exp = exp_q.pop_front();
          if (prev !== exp) begin
            failures++; $display("FAIL rand_result beat=%0d got=%h want=%h", n_out, prev, exp);
          end
        end
        n_out++;
      end
      if (bus.in_valid && bus.in_ready) exp_q.push_back(model(32'(a), 32'(b), cin, sub));
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL rand_drain left got=%0d want=0", exp_q.size());
    end
  endtask

  task automatic test_reset_flush();
    int stale = 0;
    for (int cyc = 0; cyc < 2; cyc++) begin
      @(negedge clk);
      drive(1'b1, 16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0);
    end
    @(negedge clk);
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (bus.out_valid !== 1'b1) begin
      failures++; $display("FAIL flush_setup out_valid got=%b want=1", bus.out_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++; $display("FAIL flush_in_ready got=%b want=0", bus.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL flush_out_valid got=%b want=0", bus.out_valid);
    end
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      #1;
      if (bus.out_valid) stale++;
    end
    checks++;
    if (stale != 0) begin
      failures++; $display("FAIL flush_stale got=%0d want=0", stale);
    end
  endtask

`ifdef ADDER_SELF_CHECK_EN
  task automatic test_self_check();
    checks++;
    if (err !== 1'b0 || err_count !== '0) begin
      failures++; $display("FAIL self_check got err=%b cnt=%0d want 0/0", err, err_count);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_flush();
`ifdef ADDER_SELF_CHECK_EN
    test_self_check();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
